// File: rtl/u_rca_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of a shared
// ripple-carry adder.
// Contents: result-register state enum, requester count, requester-ID width.
package u_rca_arbiter_pkg;

    // Number of requesters; the round-robin logic assumes exactly four.
    localparam int unsigned NREQ = 4;
    // Width of a requester index.
    localparam int unsigned ID_W = 2;

    // State of the single-entry result register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage : u_rca_arbiter_pkg

// File: rtl/u_rca_arbiter_rca.sv
// u_rca_core: unsigned WIDTH-bit ripple-carry adder, carry-in tied to zero.
// Ports:
//   i_a, i_b : WIDTH-bit operands
//   o_sum    : WIDTH+1-bit sum, carry-out in the MSB
module u_rca_core #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    // One full adder per bit, carry rippling from bit 0 upward.
    always_comb begin
        w_c = '0;
        w_s = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_sum = {w_c[WIDTH], w_s};

endmodule : u_rca_core

// File: rtl/u_rca_arbiter.sv
// u_rca_arbiter: four requesters share one ripple-carry adder through a
// round-robin grant; the sum is held in a single-entry result register.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: per-requester handshake (req_ready combinational)
//   req_a, req_b       : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready: result handshake
//   rsp_out, rsp_id    : registered sum (carry in MSB) and owning requester
//   grant_cnt          : 16-bit wrapping grant counter, only when
//                        U_RCA_ARBITER_PERF_EN is defined
module u_rca_arbiter #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NREQ  = u_rca_arbiter_pkg::NREQ
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ*WIDTH-1:0]               req_a,
    input  logic [NREQ*WIDTH-1:0]               req_b,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [WIDTH:0]                      rsp_out,
    output logic [u_rca_arbiter_pkg::ID_W-1:0]  rsp_id
`ifdef U_RCA_ARBITER_PERF_EN
    ,
    output logic [15:0]                         grant_cnt
`endif
);

    import u_rca_arbiter_pkg::*;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [WIDTH:0]   r_rsp_out;
    logic [ID_W-1:0]  r_rsp_id;

    logic             w_can_accept;
    logic             w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_idx;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    // Round-robin pick: scan offsets high to low so the lowest offset from
    // r_ptr (the first in search order) is the one left standing.
    always_comb begin
        w_can_accept = (r_state == EMPTY) || rsp_ready;
        w_gnt        = 1'b0;
        w_gnt_idx    = '0;
        w_idx        = '0;
        req_ready    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_idx = r_ptr + ID_W'(k);
            if (req_valid[w_idx]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        w_gnt = w_gnt && w_can_accept && !rst;
        req_ready[w_gnt_idx] = w_gnt;
    end

    // Operand mux driven only by the grant index, never by operand data.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (ID_W'(k) == w_gnt_idx) begin
                w_a = req_a[k*WIDTH +: WIDTH];
                w_b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    u_rca_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    // Next state: a grant always leaves a result; a drain without a grant empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_gnt) w_state_nxt = FULL;
            FULL:    if (rsp_ready && !w_gnt) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // State, pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_ptr     <= '0;
            r_rsp_out <= '0;
            r_rsp_id  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt) begin
                r_ptr     <= w_gnt_idx + ID_W'(1);
                r_rsp_out <= w_sum;
                r_rsp_id  <= w_gnt_idx;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_out   = r_rsp_out;
    assign rsp_id    = r_rsp_id;

`ifdef U_RCA_ARBITER_PERF_EN
    logic [15:0] r_grant_cnt;

    // Grant counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else if (w_gnt) begin
            r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule : u_rca_arbiter

// File: tb/tb_u_rca_arbiter.sv
// Directed self-checking bench for u_rca_arbiter (WIDTH=5).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_u_rca_arbiter;

    localparam int unsigned W  = 5;
    localparam int unsigned NR = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_out;
    logic [1:0]        rsp_id;
`ifdef U_RCA_ARBITER_PERF_EN
    logic [15:0]       grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    u_rca_arbiter #(
        .WIDTH (W),
        .NREQ  (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
`ifdef U_RCA_ARBITER_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;

        // Reset: no grants while rst is high, cleared result afterwards.
        #1;
        check_eq("rst_ready_0", 32'(req_ready), 32'b0000);
        tick();
        tick();
        check_eq("rst_ready_1", 32'(req_ready), 32'b0000);
        check_eq("rst_valid", 32'(rsp_valid), 0);
        check_eq("rst_out", 32'(rsp_out), 0);
        check_eq("rst_id", 32'(rsp_id), 0);
        rst = 1'b0;

        // Round-robin sweep with all requesters valid: 0,1,2,3 then back to 0.
        set_ops(0, 5'd1, 5'd10);
        set_ops(1, 5'd2, 5'd20);
        set_ops(2, 5'd3, 5'd30);
        set_ops(3, 5'd4, 5'd31);
        req_valid = 4'b1111;
        #1;
        check_eq("rr_ready_0", 32'(req_ready), 32'b0001);
        tick();
        check_eq("rr_id_0", 32'(rsp_id), 0);
        check_eq("rr_out_0", 32'(rsp_out), 11);
        check_eq("rr_ready_1", 32'(req_ready), 32'b0010);
        tick();
        check_eq("rr_id_1", 32'(rsp_id), 1);
        check_eq("rr_out_1", 32'(rsp_out), 22);
        check_eq("rr_ready_2", 32'(req_ready), 32'b0100);
        tick();
        check_eq("rr_id_2", 32'(rsp_id), 2);
        check_eq("rr_out_2", 32'(rsp_out), 33);
        check_eq("rr_ready_3", 32'(req_ready), 32'b1000);
        tick();
        check_eq("rr_id_3", 32'(rsp_id), 3);
        check_eq("rr_out_3", 32'(rsp_out), 35);
        check_eq("rr_valid_3", 32'(rsp_valid), 1);
        check_eq("rr_ptr_wrap", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();
        check_eq("rr_drain_valid", 32'(rsp_valid), 0);

        // Single request from 0: 28+5 with latency 1.
        set_ops(0, 5'd28, 5'd5);
        req_valid = 4'b0001;
        #1;
        check_eq("one_ready", 32'(req_ready), 32'b0001);
        tick();
        check_eq("one_valid", 32'(rsp_valid), 1);
        check_eq("one_out", 32'(rsp_out), 33);
        check_eq("one_id", 32'(rsp_id), 0);
        req_valid = 4'b0000;
        tick();
        check_eq("one_drain", 32'(rsp_valid), 0);

        // Pointer is 1: grant requester 1 to move it to 2.
        req_valid = 4'b0010;
        tick();
        check_eq("ptr2_id", 32'(rsp_id), 1);
        // Pointer 2 with 0011: wrap-around search picks 0, then 1.
        req_valid = 4'b0011;
        #1;
        check_eq("wrap_ready_0", 32'(req_ready), 32'b0001);
        tick();
        check_eq("wrap_id_0", 32'(rsp_id), 0);
        check_eq("wrap_ready_1", 32'(req_ready), 32'b0010);
        tick();
        check_eq("wrap_id_1", 32'(rsp_id), 1);
        req_valid = 4'b0000;
        tick();

        // Max operands on requester 2, then back-pressure for 3 cycles.
        set_ops(2, 5'd31, 5'd31);
        req_valid = 4'b0100;
        #1;
        check_eq("max_ready", 32'(req_ready), 32'b0100);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("stall_ready", 32'(req_ready), 32'b0000);
            check_eq("stall_out", 32'(rsp_out), 62);
            check_eq("stall_id", 32'(rsp_id), 2);
            check_eq("stall_valid", 32'(rsp_valid), 1);
            tick();
        end
        check_eq("stall_out_end", 32'(rsp_out), 62);
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        check_eq("stall_drain", 32'(rsp_valid), 0);

        // Reset while FULL discards the held result.
        set_ops(0, 5'd28, 5'd5);
        req_valid = 4'b0001;
        tick();
        check_eq("mid_full", 32'(rsp_out), 33);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(req_ready), 32'b0000);
        tick();
        check_eq("mid_rst_valid", 32'(rsp_valid), 0);
        check_eq("mid_rst_out", 32'(rsp_out), 0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check_eq("mid_rst_stay", 32'(rsp_valid), 0);
        req_valid = 4'b1111;
        #1;
        check_eq("mid_rst_ptr", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

`ifdef U_RCA_ARBITER_PERF_EN
        // 70000 back-to-back grants wrap the 16-bit counter to 4464.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("cnt_rst", 32'(grant_cnt), 0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 70000; c++) tick();
        req_valid = 4'b0000;
        tick();
        check_eq("cnt_wrap", 32'(grant_cnt), 4464);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_u_rca_arbiter

// File: doc/u_rca_arbiter.md
U_RCA_ARBITER -- requirements
Module: u_rca_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the operand width of the shared unsigned ripple-carry adder.
REQ-002 SHALL have parameter NREQ, fixed at 4, giving the number of requesters; only the value 4 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NREQ bits: bit i high means requester i presents an operand pair.
REQ-006 SHALL have port req_ready, output, NREQ bits: bit i high means requester i is granted this cycle.
REQ-007 SHALL have port req_a, input, NREQ*WIDTH bits: operand a of requester i is bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b, input, NREQ*WIDTH bits: operand b of requester i, packed the same way as req_a.
REQ-009 SHALL have port rsp_valid, output, 1 bit: high means the result register holds a result.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port rsp_out, output, WIDTH+1 bits: the registered sum a+b, with the carry in the MSB.
REQ-012 SHALL have port rsp_id, output, 2 bits: index of the requester that owns rsp_out.

Function
REQ-013 SHALL have two states: EMPTY (no result held) and FULL (result held); rsp_valid is high in FULL only.
REQ-014 SHALL compute can_accept = EMPTY or (FULL and rsp_ready).
REQ-015 SHALL assert at most one req_ready bit per cycle, and only when can_accept is high and that requester's req_valid is high.
REQ-016 SHALL choose the grant by round-robin: search from pointer ptr upward, modulo 4; the first requester with req_valid high wins.
REQ-017 SHALL update ptr to (granted index + 1) mod 4 on a grant, and hold ptr when there is no grant.
REQ-018 SHALL, on a grant at cycle N, register rsp_out = zero-extended req_a + req_b and rsp_id = granted index, and raise rsp_valid at cycle N+1 (latency 1).
REQ-019 SHALL, in FULL with rsp_ready high and a grant in the same cycle, replace the held result with the new one and stay FULL, sustaining one result per cycle.
REQ-020 SHALL, in FULL with rsp_ready high and no grant, go to EMPTY.
REQ-021 SHALL, in FULL with rsp_ready low, hold rsp_out and rsp_id stable and keep req_ready all-zero.
REQ-022 SHALL never overflow: the maximum sum, 2*(2^WIDTH-1), fits in WIDTH+1 bits; for example, 31+31 gives 62.
REQ-023 SHALL drive req_ready combinationally from req_valid, ptr, the state and rsp_ready, with no combinational path from req_a or req_b to any output.

Reset
REQ-024 SHALL, while rst is high at a clock edge, force state EMPTY, ptr=0, rsp_out=0, rsp_id=0 and rsp_valid=0.
REQ-025 SHALL hold req_ready all-zero while rst is high.
REQ-026 SHALL, on reset mid-operation, discard any held result without delivering it.

Configuration
REQ-027 SHALL, with macro U_RCA_ARBITER_PERF_EN defined, add output grant_cnt (16 bits), which counts grants, wraps from 65535 to 0 and is cleared by rst.
REQ-028 SHALL, without U_RCA_ARBITER_PERF_EN, omit the grant_cnt port and its counter entirely, with all other behaviour identical.

Structure
REQ-029 SHALL place the state enum (EMPTY, FULL), NREQ=4 and the ID width constant (2) in the shared package u_rca_arbiter_pkg.
REQ-030 SHALL instantiate the adder as one sub-module, u_rca_core (WIDTH-bit unsigned ripple-carry adder, output WIDTH+1 bits), fed by the grant multiplexer.

Verification
REQ-031 SHALL cover: req_valid=0001, a0=28, b0=5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_out=33, rsp_id=0.
REQ-032 SHALL cover: req_valid=1111 held for 4 cycles, rsp_ready=1 -> grants to 0,1,2,3 on consecutive cycles, then ptr=0.
REQ-033 SHALL cover: a2=31, b2=31 granted, then rsp_ready=0 for 3 cycles -> rsp_out=62, rsp_id=2 held, req_ready=0000 throughout.
REQ-034 SHALL cover: ptr=2, req_valid=0011 -> req_ready=0001 first, then 0010 on the next cycle.
REQ-035 SHALL cover: rst pulsed for one cycle while FULL -> rsp_valid=0 and rsp_out=0 on the next cycle, with the result never delivered.
REQ-036 SHALL cover: with U_RCA_ARBITER_PERF_EN, 70000 grants -> grant_cnt=4464.
